// File: rtl/ascii_uart_tx.sv
// ASCII byte sink: small FIFO in front of an 8N1 UART transmitter.
// One frame per FIFO entry, LSB first, with one idle cycle between frames.
module ascii_uart_tx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q;
    logic             full, push, pop;

    // Transmitter state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             baud_tc;

    assign full = (count_q == FIFO_FULL);
    // A full FIFO rejects writes even when a pop frees a slot on the same edge.
    assign push = din_valid & ~full;
    assign pop  = (state_q == StIdle) & (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            if (din_valid && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign baud_tc = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StData: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so txd is a clean flop output.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign din_ready  = ~full;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Randomised bench for ascii_uart_tx against a queue-plus-frame-timer reference model.
module tb_ascii_uart_tx;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DEPTH  = 4;
    localparam int          CPB    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, txd, busy, overflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int peak_obs = 0;

    // Reference model: bytes waiting, plus the frame currently on the line.
    logic [7:0] mq[$];
    bit         m_busy = 0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 0;

    ascii_uart_tx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .txd       (txd),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit k of 10: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_t    = 0;
        m_ovf  = 0;
    endtask

    task automatic model_update();
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (din_valid && was_full) m_ovf = 1;
        if (m_busy) begin
            m_t++;
            if (m_t == 10 * CPB) m_busy = 0;
        end else if (mq.size() != 0) begin
            m_byte = mq.pop_front();
            m_busy = 1;
            m_t    = 0;
        end
        if (din_valid && !was_full) mq.push_back(din);
    endtask

    task automatic check_all();
        chk("txd", {31'd0, txd}, {31'd0, (m_busy ? frame_bit(m_byte, m_t) : 1'b1)});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("fifo_count", {29'd0, fifo_count}, mq.size());
        chk("din_ready", {31'd0, din_ready}, {31'd0, (mq.size() != DEPTH)});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    // Called at a negedge; applies inputs, steps the model on the posedge, checks at next negedge.
    task automatic step(input logic v, input logic [7:0] d);
        din_valid = v;
        din       = v ? d : 8'($urandom);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
        if (int'(fifo_count) > peak_obs) peak_obs = int'(fifo_count);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic async_reset();
        #2;
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_ready", {31'd0, din_ready}, 32'd1);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pct [5];
        pct = '{5, 30, 60, 2, 90};

        @(negedge clk);
        @(negedge clk);
        chk("init_txd", {31'd0, txd}, 32'd1);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_count", {29'd0, fifo_count}, 32'd0);
        chk("init_ready", {31'd0, din_ready}, 32'd1);
        chk("init_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        idle(3);

        // Single byte: written on edge N, start bit from edge N+1.
        step(1'b1, 8'h41);
        chk("single_cnt_after_write", {29'd0, fifo_count}, 32'd1);
        chk("single_txd_after_write", {31'd0, txd}, 32'd1);
        step(1'b0, 8'h00);
        chk("single_txd_start", {31'd0, txd}, 32'd0);
        chk("single_cnt_after_pop", {29'd0, fifo_count}, 32'd0);
        idle(110);

        // Burst of three.
        peak_obs = 0;
        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        idle(320);
        chk("burst_peak", peak_obs, 32'd2);

        // Overflow while a frame is on the line.
        step(1'b1, 8'h41);
        idle(5);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h61 + i));
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_ready_low", {31'd0, din_ready}, 32'd0);
        idle(600);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Push on the pop edge.
        step(1'b1, 8'h20);
        step(1'b1, 8'h7A);
        chk("pushpop_count", {29'd0, fifo_count}, 32'd1);
        idle(250);

        // Reset in the middle of a data bit with two bytes queued.
        step(1'b1, 8'h55);
        step(1'b1, 8'h0A);
        step(1'b1, 8'h0B);
        idle(35);
        async_reset();
        idle(150);
        chk("post_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("post_rst_txd", {31'd0, txd}, 32'd1);

        // Random traffic with varying write density and occasional resets.
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 399) == 0) async_reset();
                else step(($urandom_range(0, 99) < pct[s]), 8'($urandom));
            end
        end
        idle(10 * CPB * (DEPTH + 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
